// File: rtl/spi_move_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_move_receiver
// Purpose  : SPI mode-0 slave front-end for player 2. It receives one 8-bit
//            move frame {HEADER, 1'b0, col[2:0]}, validates it, and presents
//            the column together with a one-cycle valid strobe in the clk
//            domain. Malformed or illegal frames give a one-cycle error strobe.
// Revision : 1.0 - initial release
// ============================================================================
module spi_move_receiver #(
   parameter int         NUM_COLS    = 7,
   parameter logic [3:0] HEADER      = 4'hA,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       spi_cs,
   output logic [2:0] selected_col,
   output logic       valid_move,
   output logic       frame_error,
   output logic       busy
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SHIFT   = 2'd1;
   localparam logic [1:0] ST_CHECK   = 2'd2;

   localparam logic [3:0] BIT_FULL   = 4'd8;
   localparam logic [3:0] BIT_MAX    = 4'd9;
   localparam logic [3:0] NUM_COLS_W = 4'(NUM_COLS);

   // Synchronizer chains; the last stage is the synced value, plus one
   // delayed copy of sclk and cs for edge detection.
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic                   sclk_dly_q;
   logic                   cs_dly_q;

   logic [1:0] state_q,       state_d;
   logic [3:0] bit_cnt_q,     bit_cnt_d;
   logic [7:0] shift_q,       shift_d;
   logic [2:0] col_q,         col_d;
   logic       valid_q,       valid_d;
   logic       ferr_q,        ferr_d;

   logic sclk_s;
   logic mosi_s;
   logic cs_s;
   logic sclk_rise;
   logic cs_fall;
   logic cs_rise;
   logic frame_ok;

   // Bring the asynchronous SPI lines into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '0;
         sclk_dly_q  <= 1'b0;
         cs_dly_q    <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
         sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
         cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign cs_fall   = ~cs_s & cs_dly_q;
   assign cs_rise   = cs_s & ~cs_dly_q;

   // A frame is legal when the header matches, bit 3 is clear and the
   // column lies on the board.
   assign frame_ok  = (shift_q[7:4] == HEADER) && !shift_q[3] &&
                      ({1'b0, shift_q[2:0]} < NUM_COLS_W);

   // Next-state logic for the frame FSM and the registered output strobes.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      col_d     = col_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // cs rises and SCLK edges are ignored while idle.
            if (cs_fall) begin
               state_d   = ST_SHIFT;
               bit_cnt_d = '0;
               shift_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               if (bit_cnt_q == BIT_FULL) begin
                  state_d = ST_CHECK;
               end else begin
                  // Short or long frame: drop it and report.
                  state_d = ST_IDLE;
                  ferr_d  = 1'b1;
               end
            end else if (sclk_rise) begin
               shift_d = {shift_q[6:0], mosi_s};
               if (bit_cnt_q != BIT_MAX) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
            if (!frame_ok) begin
               ferr_d = 1'b1;
            end else if (enable) begin
               col_d   = shift_q[2:0];
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         col_q     <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         col_q     <= col_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign selected_col = col_q;
   assign valid_move   = valid_q;
   assign frame_error  = ferr_q;
   assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire
